// File: rtl/rgb_pkg.sv
// rgb_pkg: colour record type and the fixed palette shared by the sequencer
package rgb_pkg;

    localparam int CH_BITS = 8;

    typedef struct packed {
        logic [CH_BITS-1:0] r;
        logic [CH_BITS-1:0] g;
        logic [CH_BITS-1:0] b;
    } color_t;

    localparam color_t PALETTE [0:7] = '{
        '{r: 8'hFF, g: 8'h00, b: 8'h00},
        '{r: 8'h00, g: 8'hFF, b: 8'h00},
        '{r: 8'h00, g: 8'h00, b: 8'hFF},
        '{r: 8'hFF, g: 8'hFF, b: 8'h00},
        '{r: 8'h00, g: 8'hFF, b: 8'hFF},
        '{r: 8'hFF, g: 8'h00, b: 8'hFF},
        '{r: 8'hFF, g: 8'hFF, b: 8'hFF},
        '{r: 8'h00, g: 8'h00, b: 8'h00}
    };

    // Palette channels are either fully off or fully on, so a lit-channel mask
    // lets the sequencer rebuild each channel at whatever PWM width it runs.
    function automatic logic [2:0] ch_mask(input color_t c);
        return {|c.b, |c.g, |c.r};
    endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: two-flop synchroniser, level debouncer and press pulse
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1200
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic step
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync0;
    logic          sync1;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clock domain before anything looks at it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= button;
            sync1 <= sync0;
        end
    end

    // Accept a new level only after it has disagreed for a full unbroken run
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync1 == level) begin
            cnt   <= '0;
        end else if (cnt == C_LAST) begin
            cnt   <= '0;
            level <= sync1;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    // Delayed copy of the debounced level for press-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            level_q <= 1'b0;
        else
            level_q <= level;
    end

    assign step = level & ~level_q;

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// rgb_pwm_sequencer: palette sequencer with button/auto advance and RGB PWM drive
module rgb_pwm_sequencer
    import rgb_pkg::*;
#(
    parameter int PWM_BITS        = 8,
    parameter int N_COLORS        = 6,
    parameter int DEBOUNCE_CYCLES = 1200,
    parameter int AUTO_PERIOD     = 12_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                button,
    input  logic                auto_en,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [2:0]          rgb,
    output logic [2:0]          color_idx
);

    localparam int AW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AW-1:0] A_LAST = AW'(AUTO_PERIOD - 1);
    localparam logic [2:0]    C_LAST = 3'(N_COLORS - 1);

    logic                  step;
    logic                  tick;
    logic                  advance;
    logic [AW-1:0]         auto_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [2:0]            mask;
    logic [2*PWM_BITS-1:0] prod [3];
    logic [PWM_BITS-1:0]   duty_next [3];
    logic [PWM_BITS-1:0]   duty [3];

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .step   (step)
    );

    assign tick    = auto_en && (auto_cnt == A_LAST);
    assign advance = step | tick;

    // Auto-advance timer: idle at zero when disabled, restarts on every advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            auto_cnt <= '0;
        else
            auto_cnt <= (!auto_en || advance) ? '0 : auto_cnt + 1'b1;
    end

    // Palette index steps once per advance and wraps after the last colour
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            color_idx <= 3'd0;
        else if (advance)
            color_idx <= (color_idx == C_LAST) ? 3'd0 : color_idx + 3'd1;
    end

    // Free-running PWM timebase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    // Scale each lit channel by brightness with a full-width product
    always_comb begin
        mask = ch_mask(PALETTE[color_idx]);
        for (int i = 0; i < 3; i++) begin
            prod[i]      = {{PWM_BITS{1'b0}}, (mask[i] ? {PWM_BITS{1'b1}} : {PWM_BITS{1'b0}})}
                         * {{PWM_BITS{1'b0}}, brightness};
            duty_next[i] = PWM_BITS'(prod[i] >> PWM_BITS);
        end
    end

    // Duties change only at the end of a period so no pulse is ever cut short
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++)
                duty[i] <= '0;
        end else if (&pwm_cnt) begin
            for (int i = 0; i < 3; i++)
                duty[i] <= duty_next[i];
        end
    end

    // Registered PWM compare per channel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rgb <= 3'b000;
        else
            rgb <= {pwm_cnt < duty[2], pwm_cnt < duty[1], pwm_cnt < duty[0]};
    end

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// tb_rgb_pwm_sequencer: directed self-checking bench for the RGB PWM sequencer
module tb_rgb_pwm_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       button = 1'b0;
    logic       auto_en = 1'b0;
    logic [7:0] brightness = 8'd128;
    logic [2:0] rgb;
    logic [2:0] color_idx;

    int n_assert = 0;
    int n_fail   = 0;
    int n;
    int hi;
    int hi_gb;
    logic p;
    int man_exp [7] = '{1, 2, 3, 4, 5, 0, 1};

    always #5 clk = ~clk;

    rgb_pwm_sequencer #(
        .PWM_BITS        (8),
        .N_COLORS        (6),
        .DEBOUNCE_CYCLES (4),
        .AUTO_PERIOD     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .auto_en    (auto_en),
        .brightness (brightness),
        .rgb        (rgb),
        .color_idx  (color_idx)
    );

    task automatic tick_n(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press();
        button = 1'b1;
        tick_n(10);
        button = 1'b0;
        tick_n(10);
    endtask

    task automatic wait_change(output int cnt, input int limit);
        logic [2:0] old;
        old = color_idx;
        cnt = 0;
        while (color_idx === old && cnt < limit) begin
            tick_n(1);
            cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick_n(3);
        chk("reset_rgb", rgb, 0);
        chk("reset_idx", color_idx, 0);
        rst = 1'b1;

        tick_n(600);
        hi = 0;
        hi_gb = 0;
        repeat (256) begin
            tick_n(1);
            hi += int'(rgb[0]);
            hi_gb += int'(rgb[2:1] != 2'b00);
        end
        chk("duty_red_128", hi, 127);
        chk("duty_gb_off", hi_gb, 0);
        chk("pwm_idx", color_idx, 0);

        brightness = 8'd255;
        tick_n(600);
        p = rgb[0];
        tick_n(1);
        n = 1;
        while (!(rgb[0] === 1'b1 && p === 1'b0) && n < 600) begin
            p = rgb[0];
            tick_n(1);
            n++;
        end
        chk("period_start_found", n < 600, 1);
        hi = int'(rgb[0]);
        for (int k = 1; k < 256; k++) begin
            if (k == 10) brightness = 8'd64;
            tick_n(1);
            hi += int'(rgb[0]);
        end
        chk("old_period_255", hi, 254);
        hi = 0;
        repeat (256) begin
            tick_n(1);
            hi += int'(rgb[0]);
        end
        chk("new_period_64", hi, 63);
        brightness = 8'd128;

        for (int i = 0; i < 7; i++) begin
            press();
            chk("manual_idx", color_idx, man_exp[i]);
        end

        for (int k = 0; k < 10; k++) begin
            button = (k % 2 == 0);
            tick_n(2);
        end
        chk("bounce_no_adv", color_idx, 1);
        button = 1'b1;
        wait_change(n, 50);
        chk("bounce_latency", n, 7);
        chk("bounce_idx", color_idx, 2);
        tick_n(10);
        button = 1'b0;
        tick_n(10);
        chk("bounce_single", color_idx, 2);

        auto_en = 1'b1;
        wait_change(n, 40);
        chk("auto_first", n, 16);
        chk("auto_idx3", color_idx, 3);
        wait_change(n, 40);
        chk("auto_period", n, 16);
        chk("auto_idx4", color_idx, 4);
        tick_n(9);
        button = 1'b1;
        wait_change(n, 40);
        chk("coinc_latency", n, 7);
        chk("coinc_idx", color_idx, 5);
        button = 1'b0;
        wait_change(n, 40);
        chk("coinc_next_tick", n, 16);
        chk("auto_wrap_idx", color_idx, 0);
        auto_en = 1'b0;
        tick_n(40);
        chk("auto_off_hold", color_idx, 0);

        for (int i = 1; i <= 3; i++) begin
            press();
            chk("pre_reset_idx", color_idx, i);
        end
        button = 1'b1;
        tick_n(4);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_rgb", rgb, 0);
        chk("rst_async_idx", color_idx, 0);
        tick_n(2);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_n(1);
            chk("post_rst_idx", color_idx, 0);
            chk("post_rst_rgb", rgb, 0);
        end
        button = 1'b0;
        tick_n(20);
        chk("no_spurious_step", color_idx, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_sequencer.md
RGB_PWM_SEQUENCER -- requirements
Module: rgb_pwm_sequencer

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8: PWM counter, brightness and palette channel width.
REQ-002 SHALL have parameter N_COLORS, default 6: number of palette entries cycled, legal range 2..8.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1200: consecutive stable cycles needed to accept a button level.
REQ-004 SHALL have parameter AUTO_PERIOD, default 12_000_000: clocks between automatic colour advances.
REQ-005 SHALL have port clk  input  1: single clock, all logic on posedge.
REQ-006 SHALL have port rst  input  1: asynchronous active-low reset.
REQ-007 SHALL have port button  input  1: raw, asynchronous, bouncing push-button level, active-high.
REQ-008 SHALL have port auto_en  input  1: 1 = auto-cycle mode, 0 = manual-only.
REQ-009 SHALL have port brightness  input  PWM_BITS: global intensity scale, sampled at PWM period boundary.
REQ-010 SHALL have port rgb  output  3: PWM drive, bit0 = red, bit1 = green, bit2 = blue, active-high.
REQ-011 SHALL have port color_idx  output  3: current palette index, registered.

Function
REQ-012 SHALL synchronise button through two flops before any other use.
REQ-013 SHALL change the debounced level only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts the count.
REQ-014 SHALL generate a one-cycle step pulse on each 0->1 transition of the debounced level; releases generate none.
REQ-015 SHALL, when auto_en=1, count clocks and emit a one-cycle tick when the count reaches AUTO_PERIOD-1, then restart from 0.
REQ-016 SHALL hold the auto counter at 0 while auto_en=0.
REQ-017 SHALL restart the auto counter from 0 on every colour advance, manual or automatic.
REQ-018 SHALL advance color_idx by one on the cycle after step or tick; step and tick in the same cycle advance it once.
REQ-019 SHALL wrap color_idx from N_COLORS-1 to 0.
REQ-020 SHALL run a free-running PWM_BITS counter that wraps from 2^PWM_BITS-1 to 0.
REQ-021 SHALL compute per-channel duty = (palette[color_idx].ch * brightness) >> PWM_BITS using a 2*PWM_BITS product.
REQ-022 SHALL load duty registers only when the PWM counter equals 2^PWM_BITS-1, so a colour or brightness change never truncates a period.
REQ-023 SHALL drive rgb[ch] = (pwm_cnt < duty[ch]), registered; duty 0 gives constant 0.
REQ-024 SHALL give maximum high time of 254/256 periods at PWM_BITS=8 (channel 255, brightness 255).

Reset
REQ-025 SHALL, while rst=0, force rgb=0, color_idx=0, PWM counter=0, all duties=0, auto counter=0, debounce count=0, debounced level=0 and synchroniser flops=0.
REQ-026 SHALL abort any debounce, auto or PWM count in progress on reset assertion.
REQ-027 SHALL emit no step pulse on the first cycles after reset release, even if button is held high.

Structure
REQ-028 SHALL place in package rgb_pkg: color_t struct (r, g, b fields of PWM_BITS each) and the 8-entry PALETTE constant: red, green, blue, yellow, cyan, magenta, white, off.
REQ-029 SHALL implement synchroniser, debouncer and rise-edge pulse as one sub-module, button_debounce, parametrised by DEBOUNCE_CYCLES.

Verification
REQ-030 SHALL cover manual cycling (DEBOUNCE_CYCLES=4, auto_en=0): 7 clean presses of 10 cycles -> color_idx 1,2,3,4,5,0,1, one step each.
REQ-031 SHALL cover bounce: button toggled every 2 cycles for 20 cycles then held high -> exactly one advance, DEBOUNCE_CYCLES+3 cycles after the final rise.
REQ-032 SHALL cover auto mode (AUTO_PERIOD=16): auto_en=1 -> color_idx advances every 16 cycles; a press coinciding with a tick -> single advance, next tick 16 cycles later.
REQ-033 SHALL cover PWM duty (PWM_BITS=8, idx 0 red, brightness 128): per 256-cycle period -> rgb[0] high 127 cycles, rgb[2:1]=0.
REQ-034 SHALL cover glitch-free update: brightness changed from 255 to 64 mid-period -> current period completes at the old duty, next period high 63 cycles.
REQ-035 SHALL cover reset mid-operation: rst pulsed low at idx 3 mid-debounce -> all outputs 0 immediately, no spurious step after release.
